data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I memory stage: byte/half/word loads and stores
// with fault detection. Define DMEM_WAIT_STATES_EN to add WAIT_CYCLES of response latency.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = DEPTH_WORDS;

`ifdef DMEM_WAIT_STATES_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int  CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam bit  USE_WAIT = (WAIT_CYCLES > 0);
  logic [CW-1:0] wait_cnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
  logic unused_cfg;
  assign unused_cfg = (WAIT_CYCLES != 0);
`endif

  state_t state;

  logic [31:0] mem [DEPTH_WORDS];

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_funct3;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_funct3;

  logic          in_range;
  logic          cur_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic [31:0]   rsp_data;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;
  logic          enter_resp;

  // In IDLE the request is decoded straight off the ports; later it comes from the latch.
  always_comb begin
    if (state == IDLE) begin
      cur_we     = req_we;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
      cur_funct3 = req_funct3;
    end else begin
      cur_we     = lat_we;
      cur_addr   = lat_addr;
      cur_wdata  = lat_wdata;
      cur_funct3 = lat_funct3;
    end
  end

  always_comb begin
    in_range = ({2'b00, cur_addr[31:2]} < DEPTH_L);
    word_idx = cur_addr[AW+1:2];
    rd_word  = in_range ? mem[word_idx] : '0;
    shifted  = rd_word >> {cur_addr[1:0], 3'b000};
    cur_err  = ~in_range;
    case (cur_funct3)
      3'd0, 3'd4: cur_err = cur_err | (cur_we & cur_funct3[2]);
      3'd1, 3'd5: cur_err = cur_err | cur_addr[0] | (cur_we & cur_funct3[2]);
      3'd2:       cur_err = cur_err | (cur_addr[1:0] != 2'b00);
      default:    cur_err = 1'b1;
    endcase
  end

  always_comb begin
    load_data = '0;
    byte_en   = 4'b0000;
    wr_data   = cur_wdata;
    case (cur_funct3)
      3'd0: begin
        load_data = {{24{shifted[7]}}, shifted[7:0]};
        byte_en   = 4'b0001 << cur_addr[1:0];
        wr_data   = {4{cur_wdata[7:0]}};
      end
      3'd1: begin
        load_data = {{16{shifted[15]}}, shifted[15:0]};
        byte_en   = 4'b0011 << cur_addr[1:0];
        wr_data   = {2{cur_wdata[15:0]}};
      end
      3'd2: begin
        load_data = rd_word;
        byte_en   = 4'b1111;
      end
      3'd4: load_data = {24'b0, shifted[7:0]};
      3'd5: load_data = {16'b0, shifted[15:0]};
      default: ;
    endcase
    rsp_data = (cur_we || cur_err) ? 32'b0 : load_data;
  end

`ifdef DMEM_WAIT_STATES_EN
  assign enter_resp = ((state == IDLE) && req_valid && !USE_WAIT) ||
                      ((state == WAIT) && (wait_cnt == CW'(1)));
`else
  assign enter_resp = (state == IDLE) && req_valid;
`endif

  // Stores land on the edge that enters RESP; reset blocks the write so an aborted request never commits.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_we && !cur_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
`ifdef DMEM_WAIT_STATES_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            req_ready  <= 1'b0;
            if (enter_resp) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rsp_data;
              resp_err   <= cur_err;
            end
`ifdef DMEM_WAIT_STATES_EN
            else begin
              state    <= WAIT;
              wait_cnt <= CW'(WAIT_CYCLES);
            end
`endif
          end
        end
`ifdef DMEM_WAIT_STATES_EN
        WAIT: begin
          if (enter_resp) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rsp_data;
            resp_err   <= cur_err;
            wait_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
`endif
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
